// File: rtl/epidemic_pkg.sv
// epidemic_pkg: shared constants and flit field helpers for the epidemic router.
//   Port indices: L=0, R=1, T=2, B=3, LOC=4, NPORT=5.
//   Flit layout, MSB first: {id[ID_W], ttl[TTL_W], payload}.
//   Helpers take the flit zero-extended to MAX_W bits plus the field widths,
//   so one package serves every parameterisation of the router.
package epidemic_pkg;

  localparam int L     = 0;
  localparam int R     = 1;
  localparam int T     = 2;
  localparam int B     = 3;
  localparam int LOC   = 4;
  localparam int NPORT = 5;
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] field_mask(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  function automatic logic [MAX_W-1:0] flit_id(input logic [MAX_W-1:0] f,
                                               input int dw, input int id_w);
    return (f >> (dw - id_w)) & field_mask(id_w);
  endfunction

  function automatic logic [MAX_W-1:0] flit_ttl(input logic [MAX_W-1:0] f,
                                                input int dw, input int id_w,
                                                input int ttl_w);
    return (f >> (dw - id_w - ttl_w)) & field_mask(ttl_w);
  endfunction

  function automatic logic [MAX_W-1:0] flit_set_ttl(input logic [MAX_W-1:0] f,
                                                    input logic [MAX_W-1:0] ttl,
                                                    input int dw, input int id_w,
                                                    input int ttl_w);
    logic [MAX_W-1:0] m;
    m = field_mask(ttl_w) << (dw - id_w - ttl_w);
    return (f & ~m) | ((ttl & field_mask(ttl_w)) << (dw - id_w - ttl_w));
  endfunction

endpackage

// File: rtl/epidemic_fifo.sv
// epidemic_fifo: synchronous FIFO, one per enabled router input.
//   clk, rstn    : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata  : write request; ignored while full
//   pop          : read request; ignored while empty
//   rdata        : current head (valid when !empty)
//   full, empty  : status, both registered-pointer derived
module epidemic_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/epidemic_router.sv
// epidemic_router: five-port flooding router node for the 2-D mesh NoC.
//   clk, rstn : clock, asynchronous active-low reset
//   i_valid/i_ready/i_data : per-port input streams (0=l 1=r 2=t 3=b 4=local)
//   o_valid/o_ready/o_data : per-port output streams, all carrying one broadcast flit
//   drop_cnt  : saturating count of flits dropped as duplicates or TTL-expired
// Handshake: a beat transfers on a port at the rising edge where valid && ready;
// valid never depends on ready, and a raised o_valid holds with stable data until it
// transfers. Each accepted flit is rebroadcast to every enabled mesh neighbour except
// its source, plus local when it came from the mesh.
module epidemic_router
  import epidemic_pkg::*;
#(
  parameter int         DW      = 16,
  parameter int         ID_W    = 6,
  parameter int         TTL_W   = 4,
  parameter int         DEPTH   = 4,
  parameter int         SEEN    = 8,
  parameter logic [4:0] PORT_EN = 5'b11111,
  parameter int         CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [4:0]          i_valid,
  output logic [4:0]          i_ready,
  input  logic [5*DW-1:0]     i_data,
  output logic [4:0]          o_valid,
  input  logic [4:0]          o_ready,
  output logic [5*DW-1:0]     o_data,
  output logic [CNT_W-1:0]    drop_cnt
);

  localparam int SW = (SEEN > 1) ? $clog2(SEEN) : 1;

  logic [NPORT-1:0][DW-1:0] heads;
  logic [NPORT-1:0]         empty;
  logic [NPORT-1:0]         full;
  logic [NPORT-1:0]         pop;

  // Input FIFOs exist only for enabled ports; a disabled port looks permanently
  // full (never ready) and empty (never requests).
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    if (PORT_EN[p]) begin : g_fifo
      epidemic_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (i_valid[p]),
        .pop   (pop[p]),
        .wdata (i_data[p*DW +: DW]),
        .rdata (heads[p]),
        .full  (full[p]),
        .empty (empty[p])
      );
    end else begin : g_off
      assign heads[p] = '0;
      assign full[p]  = 1'b1;
      assign empty[p] = 1'b1;
    end
  end

  assign i_ready = rstn ? (PORT_EN & ~full) : '0;

  // Broadcast stage, history and arbiter state.
  logic [NPORT-1:0] pending;
  logic [DW-1:0]    bcast;
  logic [ID_W-1:0]  seen_id [SEEN];
  logic [SEEN-1:0]  seen_v;
  logic [SW-1:0]    wr_ptr;
  logic [2:0]       rr_ptr;

  logic [NPORT-1:0] fire;
  logic             can_load;
  logic             found;
  logic [2:0]       gnt;
  logic [3:0]       cand_sum;
  logic [DW-1:0]    gnt_flit;
  logic [MAX_W-1:0] head_ext;
  logic [ID_W-1:0]  head_id;
  logic [TTL_W-1:0] head_ttl;
  logic [TTL_W-1:0] new_ttl;
  logic             from_loc;
  logic             hit;
  logic             drop;
  logic             take;
  logic [DW-1:0]    fwd_flit;
  logic [NPORT-1:0] new_mask;

  assign fire    = pending & o_ready;
  assign o_valid = pending;
  assign o_data  = {NPORT{bcast}};

  always_comb begin
    // The stage may refill in the same cycle its last pending port completes.
    can_load = ((pending & ~fire) == '0);

    found    = 1'b0;
    gnt      = '0;
    cand_sum = '0;
    for (int k = 0; k < NPORT; k++) begin
      cand_sum = {1'b0, rr_ptr} + 4'(k);
      if (cand_sum >= 4'(NPORT)) cand_sum = cand_sum - 4'(NPORT);
      if (!found && !empty[cand_sum[2:0]]) begin
        found = 1'b1;
        gnt   = cand_sum[2:0];
      end
    end

    gnt_flit            = heads[gnt];
    head_ext            = '0;
    head_ext[DW-1:0]    = gnt_flit;
    head_id             = ID_W'(flit_id(head_ext, DW, ID_W));
    head_ttl            = TTL_W'(flit_ttl(head_ext, DW, ID_W, TTL_W));
    from_loc            = (gnt == 3'(LOC));

    hit = 1'b0;
    for (int i = 0; i < SEEN; i++) begin
      if (seen_v[i] && (seen_id[i] == head_id)) hit = 1'b1;
    end

    // Local injections bypass the TTL check so a ttl=0 flit still reaches
    // the neighbours once (they then drop it).
    drop = hit || (!from_loc && (head_ttl == '0));
    take = can_load && found;

    pop = '0;
    if (take) pop[gnt] = 1'b1;

    new_ttl  = from_loc ? head_ttl : (head_ttl - TTL_W'(1));
    fwd_flit = DW'(flit_set_ttl(head_ext, MAX_W'(new_ttl), DW, ID_W, TTL_W));
    new_mask = {!from_loc, PORT_EN[3:0] & ~(4'b0001 << gnt)};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending  <= '0;
      bcast    <= '0;
      seen_v   <= '0;
      wr_ptr   <= '0;
      rr_ptr   <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < SEEN; i++) seen_id[i] <= '0;
    end else begin
      if (take) begin
        rr_ptr <= (gnt == 3'(LOC)) ? 3'd0 : (gnt + 3'd1);
      end
      if (take && drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (take && !drop) begin
        pending         <= new_mask;
        bcast           <= fwd_flit;
        seen_id[wr_ptr] <= head_id;
        seen_v[wr_ptr]  <= 1'b1;
        wr_ptr          <= wr_ptr + 1'b1;
      end else begin
        pending <= pending & ~fire;
      end
    end
  end

endmodule

// File: tb/tb_epidemic_router.sv
// tb_epidemic_router: directed bench for epidemic_router.
//   dut   : full node, all ports enabled
//   dut_c : corner node (PORT_EN=5'b10101) with a 2-bit drop counter
module tb_epidemic_router;
  import epidemic_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int SEEN  = 8;

  logic             clk;
  logic             rstn;
  logic [4:0]       i_valid, i_ready, o_valid, o_ready;
  logic [5*DW-1:0]  i_data, o_data;
  logic [15:0]      drop_cnt;
  logic [4:0]       i_valid_c, i_ready_c, o_valid_c, o_ready_c;
  logic [5*DW-1:0]  i_data_c, o_data_c;
  logic [1:0]       drop_cnt_c;

  int n_checks = 0;
  int n_errors = 0;
  int bcast_cnt = 0;
  int base;
  logic mon_en = 1'b0;
  logic [DW-1:0] exp_q[$];

  epidemic_router #(.DW(DW), .ID_W(6), .TTL_W(4), .DEPTH(DEPTH), .SEEN(SEEN),
                    .PORT_EN(5'b11111), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .drop_cnt(drop_cnt));

  epidemic_router #(.DW(DW), .ID_W(6), .TTL_W(4), .DEPTH(DEPTH), .SEEN(SEEN),
                    .PORT_EN(5'b10101), .CNT_W(2)) dut_c (
    .clk(clk), .rstn(rstn), .i_valid(i_valid_c), .i_ready(i_ready_c), .i_data(i_data_c),
    .o_valid(o_valid_c), .o_ready(o_ready_c), .o_data(o_data_c), .drop_cnt(drop_cnt_c));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] flit(input logic [5:0] id, input logic [3:0] ttl,
                                         input logic [5:0] pay);
    return {id, ttl, pay};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    i_valid = '0;
    i_valid_c = '0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  // Driver: present a flit on one port of dut until accepted.
  task automatic send(input int port, input logic [DW-1:0] f);
    int n;
    n = 0;
    i_data[port*DW +: DW] = f;
    i_valid[port] = 1'b1;
    while (!i_ready[port] && n < 100) begin
      tick();
      n++;
    end
    check($sformatf("send_ready_p%0d", port), 64'(i_ready[port]), 64'd1);
    tick();
    i_valid[port] = 1'b0;
  endtask

  // Monitor: counts broadcast cycles; scoreboards port T while enabled.
  always begin
    @(negedge clk);
    #2;
    if (o_valid != '0) bcast_cnt++;
    if (mon_en && o_valid[T] && o_ready[T]) begin
      if (exp_q.size() == 0) check("stall_unexpected_beat", 64'(o_valid[T]), 64'd0);
      else check("stall_t_data", 64'(o_data[T*DW +: DW]), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    rstn = 1'b0;
    i_valid = '0; i_data = '0; o_ready = '0;
    i_valid_c = '0; i_data_c = '0; o_ready_c = '1;
    tick();
    tick();
    check("rst_i_ready", 64'(i_ready), 64'd0);
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_data", 64'(o_data[DW-1:0]), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rstn = 1'b1;
    tick();
    check("post_rst_i_ready", 64'(i_ready), 64'h1f);
    check("corner_i_ready", 64'(i_ready_c), 64'h15);

    // Local inject id=5 ttl=3: mesh only, ttl unchanged; mask clears per port.
    send(LOC, flit(6'd5, 4'd3, 6'h2a));
    tick();
    check("loc_o_valid", 64'(o_valid), 64'h0f);
    check("loc_o_data_l", 64'(o_data[L*DW +: DW]), 64'(flit(6'd5, 4'd3, 6'h2a)));
    check("loc_o_data_b", 64'(o_data[B*DW +: DW]), 64'(flit(6'd5, 4'd3, 6'h2a)));
    o_ready[L] = 1'b1;
    tick();
    check("loc_partial_clear", 64'(o_valid), 64'h0e);
    o_ready = '1;
    tick();
    check("loc_all_clear", 64'(o_valid), 64'd0);

    // Left input id=7 ttl=2: r,t,b,local with ttl=1.
    send(L, flit(6'd7, 4'd2, 6'd1));
    tick();
    check("left_o_valid", 64'(o_valid), 64'h1e);
    check("left_o_data_r", 64'(o_data[R*DW +: DW]), 64'(flit(6'd7, 4'd1, 6'd1)));
    check("left_o_data_loc", 64'(o_data[LOC*DW +: DW]), 64'(flit(6'd7, 4'd1, 6'd1)));
    tick();
    check("left_done", 64'(o_valid), 64'd0);
    send(T, flit(6'd7, 4'd2, 6'd3));
    tick();
    check("dup_no_output", 64'(o_valid), 64'd0);
    check("dup_drop_cnt", 64'(drop_cnt), 64'd1);

    // Same id=9 on left and right in one cycle: left wins (rr pointer at 3).
    i_data[L*DW +: DW] = flit(6'd9, 4'd4, 6'd1);
    i_data[R*DW +: DW] = flit(6'd9, 4'd4, 6'd2);
    i_valid = 5'b00011;
    tick();
    i_valid = '0;
    tick();
    check("same_id_o_valid", 64'(o_valid), 64'h1e);
    check("same_id_o_data", 64'(o_data[T*DW +: DW]), 64'(flit(6'd9, 4'd3, 6'd1)));
    tick();
    check("same_id_second_dropped", 64'(o_valid), 64'd0);
    check("same_id_drop_cnt", 64'(drop_cnt), 64'd2);

    // Local ttl=0 is forwarded with ttl=0.
    send(LOC, flit(6'd30, 4'd0, 6'd5));
    tick();
    check("loc_ttl0_o_valid", 64'(o_valid), 64'h0f);
    check("loc_ttl0_o_data", 64'(o_data[R*DW +: DW]), 64'(flit(6'd30, 4'd0, 6'd5)));

    // Corner node: left id=3 ttl=1 goes only to t and local.
    i_data_c[L*DW +: DW] = flit(6'd3, 4'd1, 6'd7);
    i_valid_c = 5'b00001;
    tick();
    i_valid_c = '0;
    tick();
    check("corner_o_valid", 64'(o_valid_c), 64'h14);
    check("corner_o_data", 64'(o_data_c[T*DW +: DW]), 64'(flit(6'd3, 4'd0, 6'd7)));
    // Four ttl=0 mesh flits saturate the 2-bit counter at 3.
    i_data_c[L*DW +: DW] = flit(6'd50, 4'd0, 6'd0);
    i_valid_c = 5'b00001;
    repeat (4) tick();
    i_valid_c = '0;
    repeat (3) tick();
    check("corner_drop_sat", 64'(drop_cnt_c), 64'd3);
    check("corner_i_ready_end", 64'(i_ready_c), 64'h15);

    // Stall port T, inject DEPTH+2 local flits.
    do_reset();
    o_ready = 5'b11011;
    for (int k = 0; k < DEPTH + 2; k++) exp_q.push_back(flit(6'(10 + k), 4'd5, 6'(k)));
    mon_en = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) send(LOC, flit(6'(10 + k), 4'd5, 6'(k)));
    check("stall_i_ready_low", 64'(i_ready[LOC]), 64'd0);
    check("stall_pending_t", 64'(o_valid), 64'h04);
    fork
      send(LOC, flit(6'(10 + DEPTH + 1), 4'd5, 6'(DEPTH + 1)));
      begin
        repeat (3) tick();
        o_ready[T] = 1'b1;
      end
    join
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) tick();
    check("stall_drain", 64'(exp_q.size()), 64'd0);
    check("stall_no_drops", 64'(drop_cnt), 64'd0);
    mon_en = 1'b0;

    // History wrap: SEEN+1 distinct ids, then the first one is new again.
    do_reset();
    o_ready = '1;
    base = bcast_cnt;
    for (int k = 0; k < SEEN + 1; k++) send(LOC, flit(6'(20 + k), 4'd3, 6'(k)));
    repeat (3) tick();
    send(LOC, flit(6'd20, 4'd3, 6'd0));
    repeat (3) tick();
    check("wrap_bcasts", 64'(bcast_cnt - base), 64'(SEEN + 2));
    check("wrap_no_drop", 64'(drop_cnt), 64'd0);
    send(LOC, flit(6'(20 + SEEN), 4'd3, 6'd1));
    repeat (3) tick();
    check("wrap_recent_dropped", 64'(drop_cnt), 64'd1);
    check("wrap_recent_no_bcast", 64'(bcast_cnt - base), 64'(SEEN + 2));

    // Asynchronous reset with a flit pending and one queued.
    o_ready = '0;
    send(LOC, flit(6'd40, 4'd1, 6'd1));
    send(LOC, flit(6'd41, 4'd1, 6'd2));
    tick();
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_o_valid", 64'(o_valid), 64'd0);
    check("midrst_i_ready", 64'(i_ready), 64'd0);
    base = bcast_cnt;
    tick();
    tick();
    rstn = 1'b1;
    o_ready = '1;
    repeat (4) tick();
    check("midrst_no_output", 64'(bcast_cnt - base), 64'd0);
    check("midrst_i_ready_after", 64'(i_ready), 64'h1f);
    check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
